shift_acc: RTL and testbench

SHIFT_ACC -- requirements
Module: shift_acc

---
 rtl/shift_acc_pkg.sv | 15 +
 rtl/shift_acc_param_shifter.sv | 32 +++
 rtl/shift_acc.sv | 114 +++++++++++
 tb/tb_shift_acc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_acc_pkg.sv
// Shared types and default geometry for the shift-accumulate block.
// Optional feature macro used by shift_acc: SHIFT_ACC_SAT_EN.
package shift_acc_pkg;

  localparam int unsigned DEF_IN_W       = 8;
  localparam int unsigned DEF_SEL_W      = 2;
  localparam int unsigned DEF_SHIFT_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_acc_param_shifter.sv
// Combinational term builder: zero-extend a partial product and shift it left
// by shift_cntrl*SHIFT_STEP, falling back to no shift when out of range.
module param_shifter
  import shift_acc_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int unsigned SHIFT_STEP = DEF_SHIFT_STEP,
  parameter int unsigned OUT_W      = 2 * IN_W
) (
  input  logic [IN_W-1:0]  inp,
  input  logic [SEL_W-1:0] shift_cntrl,
  output logic [OUT_W-1:0] term
);

  localparam int unsigned MAX_SHIFT = OUT_W - IN_W;

  logic [OUT_W-1:0] ext;
  int unsigned      shamt;

  always_comb begin
    ext   = OUT_W'(inp);
    shamt = 32'(shift_cntrl) * SHIFT_STEP;
    // A shift that would push bits past the top is treated as no shift at all.
    if (shamt > MAX_SHIFT) begin
      term = ext;
    end else begin
      term = ext << shamt;
    end
  end

endmodule

// File: rtl/shift_acc.sv
// Shift-and-accumulate engine with IDLE/ACCUM/HOLD handshake FSM.
// Define SHIFT_ACC_SAT_EN to saturate on carry-out instead of wrapping.
module shift_acc
  import shift_acc_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int unsigned SHIFT_STEP = DEF_SHIFT_STEP,
  parameter int unsigned OUT_W      = 2 * IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inp,
  input  logic [SEL_W-1:0] shift_cntrl,
  input  logic             start,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] acc_out,
  output logic             overflow
);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [OUT_W-1:0] term;
  logic [OUT_W:0]   sum;
  logic             accept;

  param_shifter #(
    .IN_W       (IN_W),
    .SEL_W      (SEL_W),
    .SHIFT_STEP (SHIFT_STEP),
    .OUT_W      (OUT_W)
  ) u_shifter (
    .inp         (inp),
    .shift_cntrl (shift_cntrl),
    .term        (term)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != ST_HOLD);
    out_valid = (state_q == ST_HOLD);
    accept    = in_valid && in_ready;
    sum       = {1'b0, acc_q} + {1'b0, term};

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = term;
          ovf_d   = 1'b0;
          state_d = last ? ST_HOLD : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          if (start) begin
            acc_d = term;
            ovf_d = 1'b0;
          end else begin
`ifdef SHIFT_ACC_SAT_EN
            // Once saturated, stay pinned at all ones until a new start.
            if (ovf_q || sum[OUT_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum[OUT_W-1:0];
            end
`else
            acc_d = sum[OUT_W-1:0];
            if (sum[OUT_W]) begin
              ovf_d = 1'b1;
            end
`endif
          end
          state_d = last ? ST_HOLD : ST_ACCUM;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_acc.sv
// Directed self-checking bench for shift_acc with hand-computed expectations.
module tb_shift_acc;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned STEP  = 4;
  localparam int unsigned OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  inp;
  logic [SEL_W-1:0] shift_cntrl;
  logic             start;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] acc_out;
  logic             overflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  shift_acc #(
    .IN_W       (IN_W),
    .SEL_W      (SEL_W),
    .SHIFT_STEP (STEP),
    .OUT_W      (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inp         (inp),
    .shift_cntrl (shift_cntrl),
    .start       (start),
    .last        (last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .acc_out     (acc_out),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one beat for exactly one rising edge; returns at the next falling edge.
  task automatic beat(input logic [7:0] d, input logic [1:0] sel, input logic s, input logic l);
    inp         = d;
    shift_cntrl = sel;
    start       = s;
    last        = l;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    start       = 1'b0;
    last        = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    inp         = '0;
    shift_cntrl = '0;
    start       = 1'b0;
    last        = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(acc_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_oval", 32'(out_valid), 32'h0);
    chk("rst_iready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    idle_cycle();

    // Four shifted beats; out_ready high outside HOLD must be ignored.
    out_ready = 1'b1;
    beat(8'hE1, 2'd0, 1'b1, 1'b0);
    chk("b1_acc", 32'(acc_out), 32'h00E1);
    chk("b1_iready", 32'(in_ready), 32'h1);
    beat(8'hE1, 2'd1, 1'b0, 1'b0);
    chk("b2_acc", 32'(acc_out), 32'h0EF1);
    beat(8'hE1, 2'd1, 1'b0, 1'b0);
    chk("b3_acc", 32'(acc_out), 32'h1D01);
    out_ready = 1'b0;
    beat(8'hE1, 2'd2, 1'b0, 1'b1);
    chk("b4_acc", 32'(acc_out), 32'hFE01);
    chk("b4_ovf", 32'(overflow), 32'h0);
    chk("b4_oval", 32'(out_valid), 32'h1);
    chk("b4_iready", 32'(in_ready), 32'h0);
    release_hold();
    chk("b4_oval_drop", 32'(out_valid), 32'h0);
    chk("b4_iready_back", 32'(in_ready), 32'h1);

    // Out-of-range shift falls back to an unshifted term.
    beat(8'h33, 2'd3, 1'b1, 1'b1);
    chk("oor_acc", 32'(acc_out), 32'h0033);
    chk("oor_oval", 32'(out_valid), 32'h1);
    release_hold();

    // Carry-out from 0xFF00 + 0xFF00.
    beat(8'hFF, 2'd2, 1'b1, 1'b0);
    chk("ovf_b1_acc", 32'(acc_out), 32'hFF00);
    chk("ovf_b1_ovf", 32'(overflow), 32'h0);
    beat(8'hFF, 2'd2, 1'b0, 1'b1);
    chk("ovf_ovf", 32'(overflow), 32'h1);
`ifdef SHIFT_ACC_SAT_EN
    chk("ovf_acc", 32'(acc_out), 32'hFFFF);
`else
    chk("ovf_acc", 32'(acc_out), 32'hFE00);
`endif
    release_hold();

    // Overflow stays sticky across a later non-carrying beat.
    beat(8'hFF, 2'd2, 1'b1, 1'b0);
    chk("stk_clear", 32'(overflow), 32'h0);
    beat(8'hFF, 2'd2, 1'b0, 1'b0);
    beat(8'h01, 2'd0, 1'b0, 1'b1);
    chk("stk_ovf", 32'(overflow), 32'h1);
`ifdef SHIFT_ACC_SAT_EN
    chk("stk_acc", 32'(acc_out), 32'hFFFF);
`else
    chk("stk_acc", 32'(acc_out), 32'hFE01);
`endif
    release_hold();

    // Back-pressure: HOLD is stable and ignores offered beats.
    beat(8'h12, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      inp         = 8'h5A + 8'(i);
      shift_cntrl = 2'd0;
      start       = 1'b1;
      last        = 1'b1;
      in_valid    = 1'b1;
      @(negedge clk);
      in_valid    = 1'b0;
      chk($sformatf("hold%0d_acc", i), 32'(acc_out), 32'h0120);
      chk($sformatf("hold%0d_oval", i), 32'(out_valid), 32'h1);
      chk($sformatf("hold%0d_iready", i), 32'(in_ready), 32'h0);
      chk($sformatf("hold%0d_ovf", i), 32'(overflow), 32'h0);
    end
    start = 1'b0;
    last  = 1'b0;
    release_hold();
    chk("hold_exit_oval", 32'(out_valid), 32'h0);
    chk("hold_exit_iready", 32'(in_ready), 32'h1);
    chk("hold_exit_acc", 32'(acc_out), 32'h0120);

    // Reset in the middle of an accumulation.
    beat(8'h11, 2'd0, 1'b1, 1'b0);
    beat(8'h22, 2'd0, 1'b0, 1'b0);
    chk("mid_acc", 32'(acc_out), 32'h0033);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_acc", 32'(acc_out), 32'h0);
    chk("mrst_oval", 32'(out_valid), 32'h0);
    chk("mrst_iready", 32'(in_ready), 32'h1);
    chk("mrst_ovf", 32'(overflow), 32'h0);
    beat(8'h01, 2'd0, 1'b1, 1'b1);
    chk("mrst_next_acc", 32'(acc_out), 32'h0001);
    chk("mrst_next_oval", 32'(out_valid), 32'h1);
    release_hold();

    // Reset while holding a result.
    beat(8'h7F, 2'd1, 1'b1, 1'b1);
    chk("hrst_pre", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("hrst_acc", 32'(acc_out), 32'h0);
    chk("hrst_oval", 32'(out_valid), 32'h0);

    // Mid-sequence start reloads the accumulator.
    beat(8'h10, 2'd0, 1'b1, 1'b0);
    beat(8'h20, 2'd0, 1'b0, 1'b0);
    chk("reld_mid", 32'(acc_out), 32'h0030);
    beat(8'h05, 2'd1, 1'b1, 1'b1);
    chk("reld_acc", 32'(acc_out), 32'h0050);
    chk("reld_ovf", 32'(overflow), 32'h0);
    release_hold();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
